// File: rtl/dmem_bridge.sv
// Bridges the core MEM-stage data port onto a req/gnt/rvalid bus.
// Adds wait states via stall, byte lanes from access size, and error/timeout reporting.
module dmem_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_d_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  whb,
    input  logic [31:0] d_addr,
    input  logic [31:0] Data_write_MEM,
    output logic [31:0] d_data,
    output logic        stall,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [1:0]     size_q;
    logic [1:0]     off_q;
    logic           err_q;

    logic           access;
    logic           illegal;
    logic           misalign;
    logic           accept;
    logic           is_half;
    logic           is_word;
    logic           last_cycle;
    logic [3:0]     be_next;
    logic [31:0]    wdata_next;
    logic [31:0]    rdata_shift;
    logic [31:0]    rdata_sized;

    assign access     = !cs_d_n && (rd ^ wr);
    assign illegal    = !cs_d_n && rd && wr;
    assign is_half    = (whb == 2'b01);
    assign is_word    = whb[1];
    assign misalign   = access && ((is_half && d_addr[0]) || (is_word && (d_addr[1:0] != 2'b00)));
    assign accept     = (state == IDLE) && access && !misalign;
    assign last_cycle = (cnt == CW'(TIMEOUT - 1));

    // Stall covers the accept cycle combinationally so the core holds its strobes from the start.
    assign stall     = accept || (state == REQ) || (state == WAIT_R);
    assign err       = err_q || ((state == IDLE) && (illegal || misalign));
    assign dbg_state = state;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = Data_write_MEM;
        case (whb)
            2'b00: begin
                be_next    = 4'b0001 << d_addr[1:0];
                wdata_next = {4{Data_write_MEM[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << {d_addr[1], 1'b0};
                wdata_next = {2{Data_write_MEM[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = Data_write_MEM;
            end
        endcase
    end

    always_comb begin
        rdata_shift = bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   rdata_sized = {24'h000000, rdata_shift[7:0]};
            2'b01:   rdata_sized = {16'h0000, rdata_shift[15:0]};
            default: rdata_sized = rdata_shift;
        endcase
    end

    // Bus handshake: bus_req is valid, bus_gnt is ready; a request transfers on the cycle both
    // are high, and addr/be/we/wdata stay constant from req rise until that cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            err_q     <= 1'b0;
            d_data    <= 32'h0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= REQ;
                        cnt       <= '0;
                        size_q    <= whb;
                        off_q     <= d_addr[1:0];
                        bus_req   <= 1'b1;
                        bus_we    <= wr;
                        bus_addr  <= {d_addr[31:2], 2'b00};
                        bus_be    <= be_next;
                        bus_wdata <= wdata_next;
                    end else if (misalign || illegal) begin
                        d_data <= 32'h0;
                    end
                end
                REQ: begin
                    cnt <= cnt + CW'(1);
                    if (bus_gnt && bus_we) begin
                        bus_req <= 1'b0;
                        state   <= DONE;
                        if (bus_err) begin
                            err_q  <= 1'b1;
                            d_data <= 32'h0;
                        end
                    end else if (last_cycle) begin
                        // A read granted on the final budget cycle cannot finish in time either.
                        bus_req <= 1'b0;
                        err_q   <= 1'b1;
                        d_data  <= 32'h0;
                        state   <= DONE;
                    end else if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    cnt <= cnt + CW'(1);
                    if (bus_rvalid) begin
                        state <= DONE;
                        if (bus_err) begin
                            err_q  <= 1'b1;
                            d_data <= 32'h0;
                        end else begin
                            d_data <= rdata_sized;
                        end
                    end else if (last_cycle) begin
                        err_q  <= 1'b1;
                        d_data <= 32'h0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: two instances (default timeout and a short one) driven by a shared
// core port, a per-access bus responder and an expected-data scoreboard.
module tb_dmem_bridge;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_s = 1'b0;
    logic        wr_s = 1'b0;
    logic [1:0]  whb_s = 2'b00;
    logic [31:0] addr_s = 32'h0;
    logic [31:0] wdata_s = 32'h0;

    logic        cs_v      [2];
    logic        gnt_v     [2];
    logic        rvalid_v  [2];
    logic [31:0] rdata_v   [2];
    logic        berr_v    [2];
    logic [31:0] d_data_v  [2];
    logic        stall_v   [2];
    logic        err_v     [2];
    logic        bus_req_v [2];
    logic        bus_we_v  [2];
    logic [31:0] bus_addr_v  [2];
    logic [3:0]  bus_be_v    [2];
    logic [31:0] bus_wdata_v [2];
    logic [1:0]  state_v     [2];

    logic [31:0] exp_q[$];
    logic [31:0] exp_d [2];
    int          n_cmp = 0;
    int          n_mis = 0;

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    dmem_bridge u_dut (
        .clk(clk), .rst_n(rst), .cs_d_n(cs_v[0]), .rd(rd_s), .wr(wr_s), .whb(whb_s),
        .d_addr(addr_s), .Data_write_MEM(wdata_s), .d_data(d_data_v[0]), .stall(stall_v[0]),
        .err(err_v[0]), .bus_req(bus_req_v[0]), .bus_we(bus_we_v[0]), .bus_addr(bus_addr_v[0]),
        .bus_be(bus_be_v[0]), .bus_wdata(bus_wdata_v[0]), .bus_gnt(gnt_v[0]),
        .bus_rvalid(rvalid_v[0]), .bus_rdata(rdata_v[0]), .bus_err(berr_v[0]),
        .dbg_state(state_v[0])
    );

    dmem_bridge #(.TIMEOUT(4), .CW(3)) u_dut_to (
        .clk(clk), .rst_n(rst), .cs_d_n(cs_v[1]), .rd(rd_s), .wr(wr_s), .whb(whb_s),
        .d_addr(addr_s), .Data_write_MEM(wdata_s), .d_data(d_data_v[1]), .stall(stall_v[1]),
        .err(err_v[1]), .bus_req(bus_req_v[1]), .bus_we(bus_we_v[1]), .bus_addr(bus_addr_v[1]),
        .bus_be(bus_be_v[1]), .bus_wdata(bus_wdata_v[1]), .bus_gnt(gnt_v[1]),
        .bus_rvalid(rvalid_v[1]), .bus_rdata(rdata_v[1]), .bus_err(berr_v[1]),
        .dbg_state(state_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model
    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b01) return a[0];
        if (sz[1]) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) begin
            case (a[1:0])
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (sz == 2'b01) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [1:0] sz, input logic [31:0] a,
                                                input logic [31:0] r);
        if (sz == 2'b00) begin
            case (a[1:0])
                2'd0: return {24'h0, r[7:0]};
                2'd1: return {24'h0, r[15:8]};
                2'd2: return {24'h0, r[23:16]};
                default: return {24'h0, r[31:24]};
            endcase
        end
        if (sz == 2'b01) return a[1] ? {16'h0, r[31:16]} : {16'h0, r[15:0]};
        return r;
    endfunction

    task automatic set_idle();
        cs_v[0] = 1'b1;
        cs_v[1] = 1'b1;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
    endtask

    // Driver + bus responder for one access on instance u
    task automatic do_access(input int u, input logic r, input logic w, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd, input int gnt_dly,
                             input int rv_dly, input logic [31:0] rdat, input logic berr,
                             input int exp_stall, input logic exp_err, input string tag);
        int   stall_cnt = 0;
        int   req_cnt = 0;
        int   wait_cnt = 0;
        bit   granted = 1'b0;
        bit   fin = 1'b0;
        bit   err_during = 1'b0;
        logic mis;
        logic [31:0] exp_dd;
        logic [31:0] got;

        mis = model_mis(sz, a);
        if (mis || exp_err) exp_dd = 32'h0;
        else if (r) exp_dd = model_rdata(sz, a, rdat);
        else exp_dd = exp_d[u];
        exp_d[u] = exp_dd;
        exp_q.push_back(exp_dd);

        @(posedge clk); #1;
        cs_v[u] = 1'b0; rd_s = r; wr_s = w; whb_s = sz; addr_s = a; wdata_s = wd;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!stall_v[u]) begin
                fin = 1'b1;
                break;
            end
            stall_cnt++;
            if (err_v[u]) err_during = 1'b1;
            gnt_v[u] = 1'b0; rvalid_v[u] = 1'b0; berr_v[u] = 1'b0;
            if (bus_req_v[u]) begin
                req_cnt++;
                check({tag, "_addr"}, bus_addr_v[u], {a[31:2], 2'b00});
                check({tag, "_be"}, {28'h0, bus_be_v[u]}, {28'h0, model_be(sz, a)});
                check({tag, "_we"}, {31'h0, bus_we_v[u]}, {31'h0, w});
                if (w) check({tag, "_wdata"}, bus_wdata_v[u], model_wdata(sz, wd));
                if (req_cnt == gnt_dly + 1) begin
                    gnt_v[u] = 1'b1;
                    berr_v[u] = w ? berr : 1'b0;
                    granted = 1'b1;
                end
            end else if (granted && r) begin
                wait_cnt++;
                if (wait_cnt == rv_dly + 1) begin
                    rvalid_v[u] = 1'b1;
                    rdata_v[u] = rdat;
                    berr_v[u] = berr;
                end
            end
        end
        gnt_v[u] = 1'b0; rvalid_v[u] = 1'b0; berr_v[u] = 1'b0;
        check({tag, "_finished"}, {31'h0, fin}, 32'h1);
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, "_err"}, {31'h0, err_v[u]}, {31'h0, exp_err | mis});
        check({tag, "_err_early"}, {31'h0, err_during}, 32'h0);
        if (mis) begin
            check({tag, "_no_req"}, 32'(req_cnt), 32'h0);
        end else begin
            check({tag, "_done_state"}, {30'h0, state_v[u]}, {30'h0, ST_DONE});
            got = exp_q.pop_front();
            check({tag, "_d_data"}, d_data_v[u], got);
        end
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check({tag, "_err_gone"}, {31'h0, err_v[u]}, 32'h0);
        if (mis) begin
            got = exp_q.pop_front();
            check({tag, "_d_data"}, d_data_v[u], got);
        end
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        logic        r;
        int          g;
        int          v;

        for (int i = 0; i < 2; i++) begin
            cs_v[i] = 1'b1; gnt_v[i] = 1'b0; rvalid_v[i] = 1'b0;
            rdata_v[i] = 32'h0; berr_v[i] = 1'b0; exp_d[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_d_data", d_data_v[0], 32'h0);
        check("rst_stall", {31'h0, stall_v[0]}, 32'h0);
        check("rst_err", {31'h0, err_v[0]}, 32'h0);
        check("rst_bus_req", {31'h0, bus_req_v[0]}, 32'h0);
        check("rst_bus_addr", bus_addr_v[0], 32'h0);
        check("rst_bus_be", {28'h0, bus_be_v[0]}, 32'h0);
        check("rst_bus_wdata", bus_wdata_v[0], 32'h0);
        check("rst_state", {30'h0, state_v[0]}, {30'h0, ST_IDLE});

        // Directed accesses
        do_access(0, 1, 0, 2'b00, 32'h1003, 32'h0, 0, 0, 32'hAABBCCDD, 0, 3, 0, "rd_byte");
        do_access(0, 0, 1, 2'b01, 32'h2002, 32'h12345678, 4, 0, 32'h0, 0, 6, 0, "wr_half_dly");
        do_access(0, 1, 0, 2'b10, 32'h3001, 32'h0, 0, 0, 32'h0, 0, 0, 0, "rd_word_mis");
        do_access(0, 1, 0, 2'b10, 32'h5000, 32'h0, 1, 2, 32'hCAFEF00D, 0, 6, 0, "rd_word_dly");
        do_access(0, 0, 1, 2'b10, 32'h4000, 32'h89ABCDEF, 0, 0, 32'h0, 1, 2, 1, "wr_buserr");
        do_access(0, 1, 0, 2'b01, 32'h6002, 32'h0, 0, 0, 32'h11223344, 0, 3, 0, "b2b_half_hi");
        do_access(0, 1, 0, 2'b00, 32'h6001, 32'h0, 0, 0, 32'h55667788, 0, 3, 0, "b2b_byte1");
        do_access(0, 1, 0, 2'b01, 32'h6000, 32'h0, 0, 0, 32'h99AABBCC, 0, 3, 0, "b2b_half_lo");
        do_access(0, 1, 0, 2'b00, 32'h6002, 32'h0, 0, 0, 32'h0F1E2D3C, 0, 3, 0, "b2b_byte2");
        do_access(0, 1, 0, 2'b10, 32'h6100, 32'h0, 0, 1, 32'h76543210, 1, 4, 1, "rd_buserr");

        // Both strobes at once
        @(posedge clk); #1;
        cs_v[0] = 1'b0; rd_s = 1'b1; wr_s = 1'b1; whb_s = 2'b10; addr_s = 32'h9000;
        @(negedge clk);
        check("illegal_err", {31'h0, err_v[0]}, 32'h1);
        check("illegal_stall", {31'h0, stall_v[0]}, 32'h0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("illegal_no_req", {31'h0, bus_req_v[0]}, 32'h0);
        check("illegal_state", {30'h0, state_v[0]}, {30'h0, ST_IDLE});
        check("illegal_err_gone", {31'h0, err_v[0]}, 32'h0);

        // Randomised accesses with random latencies
        for (int i = 0; i < 12; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = {16'h7000, 16'($urandom_range(0, 65535))};
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            r  = 1'($urandom_range(0, 1));
            g  = $urandom_range(0, 3);
            v  = $urandom_range(0, 3);
            do_access(0, r, !r, sz, a, $urandom, g, v, $urandom, 0,
                      r ? 3 + g + v : 2 + g, 0, "rand");
        end
        do_access(0, 1, 0, 2'b10, 32'h7F00, 32'h0, 0, 0, 32'h5A5AA5A5, 0, 3, 0, "rd_pre_rst");

        // Short-timeout instance: good read, timed-out read, then a new access is accepted
        do_access(1, 1, 0, 2'b10, 32'hA000, 32'h0, 0, 0, 32'h13572468, 0, 3, 0, "to_ok1");
        do_access(1, 1, 0, 2'b10, 32'hA004, 32'h0, 0, 1000, 32'h0, 0, 5, 1, "to_abort");
        do_access(1, 1, 0, 2'b00, 32'hA009, 32'h0, 0, 0, 32'h24681357, 0, 3, 0, "to_ok2");

        // Reset while a request is outstanding
        @(posedge clk); #1;
        cs_v[0] = 1'b0; rd_s = 1'b1; wr_s = 1'b0; whb_s = 2'b10; addr_s = 32'h8000;
        @(posedge clk); #1;
        check("rst_mid_req_before", {31'h0, bus_req_v[0]}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_req_drop", {31'h0, bus_req_v[0]}, 32'h0);
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_state", {30'h0, state_v[0]}, {30'h0, ST_IDLE});
        check("rst_mid_d_data", d_data_v[0], 32'h0);
        check("rst_mid_stall", {31'h0, stall_v[0]}, 32'h0);
        rvalid_v[0] = 1'b1;
        rdata_v[0] = 32'hDEADBEEF;
        @(negedge clk);
        rvalid_v[0] = 1'b0;
        @(negedge clk);
        check("late_rvalid_d_data", d_data_v[0], 32'h0);
        check("late_rvalid_state", {30'h0, state_v[0]}, {30'h0, ST_IDLE});
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge sitting directly downstream of the pipelined core's MEM stage: consumes the core's data-port strobes (`cs_d_n`, `rd`, `wr`, `d_addr`, `Data_write_MEM`) and drives a request/grant/response bus to data memory or peripherals. It inserts wait states through `stall` and generates byte lanes from the access size. It returns LSB-aligned, zero-extended read data on `d_data`; sign extension stays in WB. It flags misaligned accesses, bus errors and timeouts.

## Interface
- `TIMEOUT`, 255: max cycles spent in REQ+WAIT_R before abort (≥2)
- `CW`, 8: timeout counter width; must hold `TIMEOUT`
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-high (1 = reset asserted)
- `cs_d_n`  in  1  core data chip-select, active-low
- `rd`  in  1  core read strobe
- `wr`  in  1  core write strobe
- `whb`  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- `d_addr`  in  32  byte address
- `Data_write_MEM`  in  32  store data, LSB-aligned
- `d_data`  out  32  read data to core, LSB-aligned and zero-extended
- `stall`  out  1  core must hold all data-port inputs stable while 1
- `err`  out  1  one-cycle pulse on misalign, illegal strobe, bus error or timeout
- `bus_req`  out  1  request valid
- `bus_we`  out  1  1 = write
- `bus_addr`  out  32  word address (`d_addr` with [1:0] = 0)
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-replicated write data
- `bus_gnt`  in  1  request accepted this cycle
- `bus_rvalid`  in  1  read data valid
- `bus_rdata`  in  32  read data
- `bus_err`  in  1  error, sampled with `bus_gnt` (writes) or `bus_rvalid` (reads)

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- Access detect in IDLE: `cs_d_n`=0 and exactly one of `rd`/`wr` high.
- Both `rd` and `wr` high is illegal: `err` pulses, no bus cycle, stay IDLE.
- Misaligned access (half with addr[0]=1, word with addr[1:0]≠0): `err` pulses, `d_data`←0, no bus cycle, `stall`=0, stay IDLE.
- Legal access: latch addr, size, we and lanes; go to REQ. `stall` is combinationally 1 in that IDLE cycle and stays 1 through REQ and WAIT_R.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Write data: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- REQ: `bus_req`=1 with `bus_addr`/`bus_be`/`bus_we`/`bus_wdata` held constant until `bus_gnt`. On gnt: a write goes to DONE; a read goes to WAIT_R. `bus_req` drops the cycle after gnt.
- WAIT_R: on `bus_rvalid`, `d_data` ← (`bus_rdata` >> 8·addr[1:0]) masked to size, then go to DONE.
- `bus_err`=1 when sampled: `err` pulses, `d_data`←0, go to DONE.
- Timeout: counter clears on entering REQ and increments each REQ/WAIT_R cycle. When it reaches `TIMEOUT`-1 without completion: `bus_req` drops, `err` pulses, `d_data`←0, go to DONE.
- DONE: `stall`=0 and `d_data` is valid; the core advances on this edge. No new access is accepted in DONE. Always return to IDLE.
- `d_data` holds its value until the next read completes, misalign or error.

## Timing
- Reset (async, immediate): state IDLE, counter 0. `d_data`, `stall`, `err`, `bus_req`, `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` all 0. Reset mid-transaction drops `bus_req` immediately. A read response arriving after reset is ignored.
- Read with zero wait: cycle 0 accept (`stall`=1); cycle 1 REQ + gnt; cycle 2 rvalid; cycle 3 DONE (`stall`=0, data valid). That is 3 stall cycles.
- Write with zero wait: cycle 0 accept; cycle 1 REQ + gnt; cycle 2 DONE. That is 2 stall cycles.
- Each extra cycle of gnt or rvalid latency adds one stall cycle.
- `err` is registered: it is high exactly in the cycle after detection. Exception: misalign/illegal raise `err` combinationally in the detect cycle.
- `bus_rvalid` outside WAIT_R is ignored. `bus_gnt` outside REQ is ignored.

## Test plan
- Reset during REQ: `bus_req` 0 the same cycle; after release, state IDLE, `d_data`=0, `stall`=0.
- Byte read addr 0x1003, `bus_rdata`=0xAABBCCDD, gnt immediate, rvalid next cycle: `bus_be`=4'b1000, `bus_addr`=0x1000; `d_data`=0x000000AA in DONE (cycle 3); `stall` high cycles 0–2.
- Half write addr 0x2002, data 0x12345678, gnt delayed 4 cycles: `bus_be`=4'b1100, `bus_wdata`=0x56785678 stable for all 5 REQ cycles; `stall` low 6 cycles after accept.
- Word read addr 0x3001: `err` pulse in the detect cycle, no `bus_req`, `d_data`=0, `stall`=0.
- Read with gnt but no rvalid, `TIMEOUT`=4: `err` pulse, `d_data`=0, DONE reached, then IDLE accepts the next access.
- Write with `bus_err`=1 on gnt: `err` pulse, then DONE; back-to-back reads on consecutive accesses each return correct lane data.
